// File: rtl/rv_pkg.sv
// Shared RISC-V instruction encoding: format select and field bit positions.
// Used by both the immediate extractor and the immediate packer.
package rv_pkg;

    typedef enum logic [2:0] {
        TYPE_R = 3'b000,
        TYPE_I = 3'b001,
        TYPE_S = 3'b010,
        TYPE_B = 3'b011,
        TYPE_U = 3'b100,
        TYPE_J = 3'b101
    } instr_type_e;

    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned OPCODE_MSB = 6;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned RD_MSB     = 11;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned FUNCT3_MSB = 14;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS1_MSB    = 19;
    localparam int unsigned RS2_LSB    = 20;
    localparam int unsigned RS2_MSB    = 24;
    localparam int unsigned FUNCT7_LSB = 25;
    localparam int unsigned FUNCT7_MSB = 31;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } pack_beat_t;

endpackage

// File: rtl/imm_pack_comb.sv
// Combinational immediate packer: scatters an immediate into the format's
// bit fields of an instruction template and flags unrepresentable values.
module imm_pack_comb
    import rv_pkg::*;
(
    input  logic [31:0] base,
    input  logic [31:0] imm,
    input  logic [2:0]  instr_type,
    output logic [31:0] instr,
    output logic        err
);

    logic sext_ok_12;
    logic sext_ok_13;
    logic sext_ok_21;

    // Upper bits must all be copies of the format's sign bit.
    assign sext_ok_12 = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign sext_ok_13 = (imm[31:12] == '0) || (imm[31:12] == '1);
    assign sext_ok_21 = (imm[31:20] == '0) || (imm[31:20] == '1);

    always_comb begin
        instr = base;
        err   = 1'b0;
        case (instr_type_e'(instr_type))
            TYPE_R: begin
                err = 1'b0;
            end
            TYPE_I: begin
                instr[FUNCT7_MSB:RS2_LSB] = imm[11:0];
                err = !sext_ok_12;
            end
            TYPE_S: begin
                instr[FUNCT7_MSB:FUNCT7_LSB] = imm[11:5];
                instr[RD_MSB:RD_LSB]         = imm[4:0];
                err = !sext_ok_12;
            end
            TYPE_B: begin
                instr[FUNCT7_MSB]              = imm[12];
                instr[FUNCT7_MSB-1:FUNCT7_LSB] = imm[10:5];
                instr[RD_MSB:RD_LSB+1]         = imm[4:1];
                instr[RD_LSB]                  = imm[11];
                err = !sext_ok_13 || imm[0];
            end
            TYPE_U: begin
                instr[FUNCT7_MSB:FUNCT3_LSB] = imm[31:12];
                err = |imm[11:0];
            end
            TYPE_J: begin
                instr[FUNCT7_MSB]              = imm[20];
                instr[FUNCT7_MSB-1:RS2_LSB+1]  = imm[10:1];
                instr[RS2_LSB]                 = imm[11];
                instr[RS1_MSB:FUNCT3_LSB]      = imm[19:12];
                err = !sext_ok_21 || imm[0];
            end
            default: begin
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_pack.sv
// Pipelined immediate packer: combinational pack stage feeding an output
// register with a one-entry skid buffer; one cycle latency, full throughput.
module imm_pack
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_base,
    input  logic [31:0] in_imm,
    input  logic [2:0]  in_instr_type,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [15:0] err_count
);

    pack_beat_t packed_beat;
    pack_beat_t skid_beat;
    logic       skid_valid;
    logic       accept;
    logic       out_free;

    imm_pack_comb u_comb (
        .base       (in_base),
        .imm        (in_imm),
        .instr_type (in_instr_type),
        .instr      (packed_beat.instr),
        .err        (packed_beat.err)
    );

    // in_ready comes straight from the skid flop, so it is registered.
    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign out_free = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_instr  <= '0;
            out_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_beat  <= '0;
        end else if (out_free) begin
            // Skid has priority to preserve order; in_ready is low while it is full.
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_instr  <= skid_beat.instr;
                out_err    <= skid_beat.err;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_instr <= packed_beat.instr;
                out_err   <= packed_beat.err;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_beat  <= packed_beat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (out_valid && out_ready && out_err && (err_count != '1)) begin
            err_count <= err_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_imm_pack.sv
// Directed self-checking bench for imm_pack: formats, error counting,
// throughput, backpressure with skid, and asynchronous reset flush.
module tb_imm_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_base;
    logic [31:0] in_imm;
    logic [2:0]  in_instr_type;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] err_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [15:0] exp_err_cnt = '0;

    imm_pack dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_base       (in_base),
        .in_imm        (in_imm),
        .in_instr_type (in_instr_type),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_err       (out_err),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    // Presents one beat from a falling edge and returns just after the accepting rising edge.
    task automatic drive_beat(input logic [31:0] b, input logic [31:0] im, input logic [2:0] t);
        int unsigned guard = 0;
        @(negedge clk);
        in_valid = 1'b1; in_base = b; in_imm = im; in_instr_type = t;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_base = '0; in_imm = '0; in_instr_type = '0;
        #2;
        n_checks++;
        if ({out_valid, out_err, out_instr, err_count, in_ready} !== {1'b0, 1'b0, 32'h0, 16'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_values: got v=%b e=%b i=%h c=%h r=%b required 0 0 00000000 0000 1",
                     out_valid, out_err, out_instr, err_count, in_ready);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_formats();
        logic [31:0] vb [14];
        logic [31:0] vi [14];
        logic [2:0]  vt [14];
        logic [31:0] ei [14];
        logic        ee [14];
        vb[0]=32'h00000093; vi[0]=32'hFFFFFFFF; vt[0]=3'b001; ei[0]=32'hFFF00093; ee[0]=1'b0;
        vb[1]=32'h00000063; vi[1]=32'h00000800; vt[1]=3'b011; ei[1]=32'h000000E3; ee[1]=1'b0;
        vb[2]=32'h00000063; vi[2]=32'h00000801; vt[2]=3'b011; ei[2]=32'h000000E3; ee[2]=1'b1;
        vb[3]=32'h000000EF; vi[3]=32'h00000004; vt[3]=3'b101; ei[3]=32'h004000EF; ee[3]=1'b0;
        vb[4]=32'h000002B7; vi[4]=32'h12345000; vt[4]=3'b100; ei[4]=32'h123452B7; ee[4]=1'b0;
        vb[5]=32'h000002B7; vi[5]=32'h12345001; vt[5]=3'b100; ei[5]=32'h123452B7; ee[5]=1'b1;
        vb[6]=32'h00000023; vi[6]=32'h00000800; vt[6]=3'b010; ei[6]=32'h80000023; ee[6]=1'b1;
        vb[7]=32'h12345678; vi[7]=32'hFFFFFFFF; vt[7]=3'b111; ei[7]=32'h12345678; ee[7]=1'b1;
        vb[8]=32'h40B50533; vi[8]=32'hDEADBEEF; vt[8]=3'b000; ei[8]=32'h40B50533; ee[8]=1'b0;
        vb[9]=32'h00000013; vi[9]=32'hFFFFF800; vt[9]=3'b001; ei[9]=32'h80000013; ee[9]=1'b0;
        vb[10]=32'h00000013; vi[10]=32'h000007FF; vt[10]=3'b001; ei[10]=32'h7FF00013; ee[10]=1'b0;
        vb[11]=32'h000000EF; vi[11]=32'hFFF00000; vt[11]=3'b101; ei[11]=32'h800000EF; ee[11]=1'b0;
        vb[12]=32'h000000EF; vi[12]=32'h00000001; vt[12]=3'b101; ei[12]=32'h000000EF; ee[12]=1'b1;
        vb[13]=32'h00000063; vi[13]=32'hFFFFF000; vt[13]=3'b011; ei[13]=32'h80000063; ee[13]=1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive_beat(vb[i], vi[i], vt[i]);
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++;
            if ({out_valid, out_instr, out_err} !== {1'b1, ei[i], ee[i]}) begin
                n_fail++;
                $display("FAIL format_%0d: got v=%b instr=%h err=%b required v=1 instr=%h err=%b",
                         i, out_valid, out_instr, out_err, ei[i], ee[i]);
            end
            if (ee[i]) exp_err_cnt++;
        end
        @(negedge clk);
        n_checks++;
        if (err_count !== exp_err_cnt) begin
            n_fail++;
            $display("FAIL format_err_count: got %0d required %0d", err_count, exp_err_cnt);
        end
    endtask

    task automatic test_err_count();
        out_ready = 1'b0;
        drive_beat(32'h00000023, 32'h00000800, 3'b010);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({out_valid, out_err, err_count} !== {1'b1, 1'b1, exp_err_cnt}) begin
            n_fail++;
            $display("FAIL err_stalled: got v=%b e=%b cnt=%0d required 1 1 %0d",
                     out_valid, out_err, err_count, exp_err_cnt);
        end
        out_ready = 1'b1;
        exp_err_cnt++;
        @(negedge clk);
        n_checks++;
        if ({out_valid, err_count} !== {1'b0, exp_err_cnt}) begin
            n_fail++;
            $display("FAIL err_drained: got v=%b cnt=%0d required 0 %0d", out_valid, err_count, exp_err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_i;
        out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp_i = (32'(i - 1) << 20) | 32'h13;
                n_checks++;
                if ({out_valid, out_instr, in_ready} !== {1'b1, exp_i, 1'b1}) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: got v=%b instr=%h rdy=%b required 1 %h 1",
                             i - 1, out_valid, out_instr, in_ready, exp_i);
                end
            end
            if (i < 4) begin
                in_valid = 1'b1; in_base = 32'h13; in_imm = 32'(i); in_instr_type = 3'b001;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [31:0] beats [3];
        int unsigned k = 0;
        int unsigned got = 0;
        logic        acc;
        beats[0] = 32'h00100013; beats[1] = 32'h00200013; beats[2] = 32'h00300013;
        for (int c = 0; c < 16 && got < 3; c++) begin
            @(negedge clk);
            out_ready = (c >= 3);
            if (c >= 1 && c <= 3) begin
                n_checks++;
                if ({out_valid, out_instr} !== {1'b1, beats[0]}) begin
                    n_fail++;
                    $display("FAIL bp_stable_c%0d: got v=%b instr=%h required 1 %h", c, out_valid, out_instr, beats[0]);
                end
            end
            if (c == 3) begin
                n_checks++;
                if ({in_ready, 32'(k)} !== {1'b0, 32'd2}) begin
                    n_fail++;
                    $display("FAIL bp_accepted: got in_ready=%b accepted=%0d required 0 2", in_ready, k);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (out_instr !== beats[got]) begin
                    n_fail++;
                    $display("FAIL bp_order_%0d: got %h required %h", got, out_instr, beats[got]);
                end
                got++;
            end
            if (k < 3) begin
                in_valid = 1'b1; in_base = 32'h13; in_imm = 32'(k + 1); in_instr_type = 3'b001;
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) k++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({32'(got), out_valid} !== {32'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_drain: got beats=%0d v=%b required 3 0", got, out_valid);
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        drive_beat(32'h12345678, 32'h0, 3'b111);
        drive_beat(32'h00000063, 32'h00000801, 3'b011);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, in_ready, out_err} !== {1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_reset_full: got v=%b rdy=%b e=%b required 1 0 1", out_valid, in_ready, out_err);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_err, out_instr, err_count, in_ready} !== {1'b0, 1'b0, 32'h0, 16'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_reset_async: got v=%b e=%b i=%h c=%h r=%b required 0 0 00000000 0000 1",
                     out_valid, out_err, out_instr, err_count, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive_beat(32'h000002B7, 32'hABCDE000, 3'b100);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_instr, out_err, err_count} !== {1'b1, 32'hABCDE2B7, 1'b0, 16'h0}) begin
            n_fail++;
            $display("FAIL post_reset_beat: got v=%b i=%h e=%b c=%0d required 1 abcde2b7 0 0",
                     out_valid, out_instr, out_err, err_count);
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, err_count} !== {1'b0, 16'h0}) begin
            n_fail++;
            $display("FAIL post_reset_drain: got v=%b c=%0d required 0 0", out_valid, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_err_count();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
